timer_dev: RTL and testbench

Programmable interval timer that drives one bit of the CPU's hardware interrupt vector. It is the interrupt source feeding CP0's `HWint` input, and it sits on the system bridge as a memory-mapped device with three word registers. The timer counts down from a CPU-written preset. It raises `irq` on expiry, either holding it until the CPU services it (one-shot) or pulsing it and reloading (periodic).

---
 rtl/timer_dev_pkg.sv | 33 +++
 rtl/timer_dev.sv | 115 +++++++++++
 tb/tb_timer_dev.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared definitions for the interval timer.
//   - register word offsets seen on addr[3:2]
//   - CTRL bit positions and MODE encodings
//   - 2-bit FSM state encoding
//   - helper that decodes MODE (1x behaves as one-shot)
package timer_dev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Only the exact 01 encoding reloads; every other value is one-shot.
    function automatic logic is_periodic(input logic [1:0] mode);
        return (mode == MODE_PERIODIC);
    endfunction

endpackage

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped programmable down-counting interval timer.
// Counts down from PRESET and raises irq on expiry; one-shot mode holds
// irq until any bus write, periodic mode pulses irq for one cycle and reloads.
// Ports:
//   clk   - system clock, all state on posedge
//   rst   - synchronous active-high reset
//   we    - bus write strobe
//   addr  - word select: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved
//   din   - write data
//   dout  - combinational read data for addr
//   irq   - interrupt request (state INT and CTRL.IM)
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:2]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic [CTRL_W-1:0]    r_ctrl;
    logic [CNT_WIDTH-1:0] r_preset;
    logic [CNT_WIDTH-1:0] r_count;
    state_t               r_state;
    state_t               w_next_state;

    logic [1:0] w_mode;
    logic       w_en;
    logic       w_cnt_zero;
    logic       w_oneshot_expire;

    assign w_mode     = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign w_en       = r_ctrl[CTRL_EN];
    assign w_cnt_zero = (r_count == '0);

    // Edge on which a one-shot run enters INT; EN self-clears on this edge.
    assign w_oneshot_expire = (r_state == ST_CNT) && w_en && w_cnt_zero &&
                              !is_periodic(w_mode);

    // State register with the down-counter alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_LOAD: r_count <= r_preset;
                ST_CNT: begin
                    // Clearing EN freezes COUNT where it is.
                    if (w_en && !w_cnt_zero)
                        r_count <= r_count - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_en) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_CNT;
            ST_CNT: begin
                if (!w_en)
                    w_next_state = ST_IDLE;
                else if (w_cnt_zero)
                    w_next_state = ST_INT;
            end
            ST_INT: begin
                // Mode is sampled here, so a change made during CNT applies now.
                if (is_periodic(w_mode))
                    w_next_state = ST_LOAD;
                else if (we)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Bus-writable registers. A CPU CTRL write beats the FSM's EN clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= '0;
            r_preset <= '0;
        end else begin
            if (we && (addr == ADDR_CTRL))
                r_ctrl <= din[CTRL_W-1:0];
            else if (w_oneshot_expire)
                r_ctrl[CTRL_EN] <= 1'b0;

            if (we && (addr == ADDR_PRESET))
                r_preset <= din[CNT_WIDTH-1:0];
        end
    end

    // Outputs.
    always_comb begin
        irq  = (r_state == ST_INT) && r_ctrl[CTRL_IM];
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = 32'(r_ctrl);
            ADDR_PRESET: dout = 32'(r_preset);
            ADDR_COUNT:  dout = 32'(r_count);
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev. Stimulus pushes expected
// irq rise cycles and per-cycle level/read expectations into queues; a
// monitor on the falling clock edge pops and compares them.
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    timer_dev #(.CNT_WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_rd;
        logic [31:0] val;
        string       name;
    } lvl_t;

    lvl_t lq[$];
    int   rq[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: level/read checks due this cycle, then irq rising edges.
    initial begin : monitor
        lvl_t        it;
        logic [31:0] act;
        bit          prev;
        int          exp_cyc;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            while (lq.size() > 0 && lq[0].cyc <= cyc) begin
                it  = lq.pop_front();
                act = it.is_rd ? dout : {31'b0, irq};
                checks++;
                if (it.cyc != cyc || act !== it.val) begin
                    errors++;
                    $display("FAIL %s: got %0h want %0h (cycle %0d, due %0d)",
                             it.name, act, it.val, cyc, it.cyc);
                end
            end
            if (irq === 1'b1 && !prev) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_irq: irq rose at cycle %0d, none expected", cyc);
                end else begin
                    exp_cyc = rq.pop_front();
                    if (exp_cyc != cyc) begin
                        errors++;
                        $display("FAIL irq_rise: rose at cycle %0d want %0d", cyc, exp_cyc);
                    end
                end
            end
            prev = (irq === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) tick();
    endtask

    // Write: the returned value is the edge on which the write lands.
    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
        e    = cyc;
    endtask

    task automatic chk_irq(input logic v, input string n);
        lq.push_back('{cyc, 1'b0, {31'b0, v}, n});
    endtask

    // Read check for the current cycle; consumes one cycle.
    task automatic chk_rd(input logic [1:0] a, input logic [31:0] v, input string n);
        addr = a;
        lq.push_back('{cyc, 1'b1, v, n});
        tick();
    endtask

    initial begin : stim
        int e, w, r;
        rst  = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        din  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_irq(1'b0, "reset_irq");
        chk_rd(2'd0, 32'h0, "reset_ctrl");
        chk_rd(2'd1, 32'h0, "reset_preset");
        chk_rd(2'd2, 32'h0, "reset_count");

        // One-shot, PRESET=5: irq at write edge + 8, held until a write
        wr(2'd1, 32'd5, w);
        wr(2'd0, 32'h9, e);
        rq.push_back(e + 8);
        wait_to(e + 3);
        chk_rd(2'd2, 32'd4, "os5_count_e3");
        wait_to(e + 8);
        chk_irq(1'b1, "os5_irq_on");
        chk_rd(2'd0, 32'h8, "os5_ctrl_en_cleared");
        wait_to(e + 11);
        chk_irq(1'b1, "os5_irq_held");
        wr(2'd1, 32'd7, w);
        chk_irq(1'b0, "os5_irq_drop");
        chk_rd(2'd2, 32'd0, "os5_count_after");
        chk_irq(1'b0, "os5_idle");

        // Periodic, PRESET=3: pulse every 6 cycles
        wr(2'd1, 32'd3, w);
        wr(2'd0, 32'hB, e);
        rq.push_back(e + 6);
        rq.push_back(e + 12);
        rq.push_back(e + 18);
        wait_to(e + 2);
        chk_rd(2'd2, 32'd3, "per_count3");
        chk_rd(2'd2, 32'd2, "per_count2");
        chk_rd(2'd2, 32'd1, "per_count1");
        chk_rd(2'd2, 32'd0, "per_count0");
        chk_irq(1'b1, "per_irq_p1");
        chk_rd(2'd0, 32'hB, "per_ctrl_kept");
        chk_irq(1'b0, "per_irq_1cycle");
        wait_to(e + 8);
        chk_rd(2'd2, 32'd3, "per2_count3");
        chk_rd(2'd2, 32'd2, "per2_count2");
        chk_rd(2'd2, 32'd1, "per2_count1");
        chk_rd(2'd2, 32'd0, "per2_count0");
        wait_to(e + 12);
        chk_irq(1'b1, "per_irq_p2");
        wait_to(e + 13);
        chk_irq(1'b0, "per_irq_p2_drop");
        wait_to(e + 19);
        wr(2'd0, 32'h0, w);

        // PRESET=0 one-shot: irq 3 cycles after the write
        wr(2'd1, 32'd0, w);
        wr(2'd0, 32'h9, e);
        rq.push_back(e + 3);
        wait_to(e + 3);
        chk_irq(1'b1, "p0_irq");
        chk_rd(2'd0, 32'h8, "p0_ctrl");
        wr(2'd0, 32'h0, w);
        chk_irq(1'b0, "p0_irq_cleared");

        // Same with IM=0: FSM still expires and clears EN, irq stays low
        wr(2'd0, 32'h1, e);
        wait_to(e + 4);
        chk_irq(1'b0, "im0_no_irq");
        chk_rd(2'd0, 32'h0, "im0_en_cleared");

        // Clear EN mid-count at COUNT=4, then re-enable
        wr(2'd1, 32'd7, w);
        wr(2'd0, 32'h9, e);
        wait_to(e + 4);
        wr(2'd0, 32'h8, w);
        wait_to(e + 8);
        chk_irq(1'b0, "stop_no_irq");
        chk_rd(2'd2, 32'd4, "stop_count_held");
        chk_rd(2'd0, 32'h8, "stop_ctrl");
        wr(2'd0, 32'h9, r);
        rq.push_back(r + 10);
        wait_to(r + 2);
        chk_rd(2'd2, 32'd7, "reload_count");
        wait_to(r + 10);
        chk_irq(1'b1, "reload_irq");

        // Reset while in INT
        rst = 1'b1;
        tick();
        chk_irq(1'b0, "rst_int_irq");
        chk_rd(2'd0, 32'h0, "rst_int_ctrl");
        chk_rd(2'd1, 32'h0, "rst_int_preset");
        chk_rd(2'd2, 32'h0, "rst_int_count");
        rst = 1'b0;

        // Reset while in CNT
        wr(2'd1, 32'd5, w);
        wr(2'd0, 32'h9, e);
        wait_to(e + 3);
        chk_rd(2'd2, 32'd4, "rst_cnt_pre");
        rst = 1'b1;
        tick();
        chk_irq(1'b0, "rst_cnt_irq");
        chk_rd(2'd2, 32'h0, "rst_cnt_count");
        rst = 1'b0;
        chk_rd(2'd0, 32'h0, "rst_cnt_ctrl");
        chk_rd(2'd1, 32'h0, "rst_cnt_preset");

        // CTRL write coincident with one-shot expiry; MODE=10 acts as one-shot
        wr(2'd1, 32'd2, w);
        wr(2'd0, 32'h9, e);
        rq.push_back(e + 5);
        wait_to(e + 4);
        wr(2'd0, 32'hD, w);
        chk_irq(1'b1, "coinc_irq");
        chk_rd(2'd0, 32'hD, "coinc_ctrl_cpu_wins");
        wait_to(e + 8);
        chk_irq(1'b1, "mode1x_held");
        wr(2'd0, 32'h0, w);
        chk_irq(1'b0, "coinc_serviced");

        tick();
        tick();
        tick();
        while (rq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL irq_missing: expected rise at cycle %0d never seen", rq.pop_front());
        end
        while (lq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked_%s: due cycle %0d", lq[0].name, lq[0].cyc);
            void'(lq.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
